// File: rtl/unita_5_ctrl.sv
// unita_5_ctrl: sequencer for the convolution unit with host weight-write arbitration
module unita_5_ctrl #(
  parameter int IFM_SIZE = 5,
  parameter int KERNAL_SIZE = 5,
  parameter int NUMBER_OF_FILTERS = 120,
  parameter int SLICES = 6,
  parameter int CONV_LATENCY = 4,
  parameter int ADDRESS_SIZE_WM = $clog2(KERNAL_SIZE * KERNAL_SIZE * NUMBER_OF_FILTERS * SLICES)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic host_we,
  input  logic [ADDRESS_SIZE_WM-1:0] host_addr,
  output logic host_err,
  input  logic ifm_valid,
  output logic ifm_ready,
  output logic wm_enable_read,
  output logic wm_enable_write,
  output logic [ADDRESS_SIZE_WM-1:0] wm_address,
  output logic wm_fifo_enable,
  output logic fifo_enable,
  output logic conv_enable,
  output logic out_valid,
  output logic [$clog2(NUMBER_OF_FILTERS)-1:0] out_filter,
  output logic [$clog2(SLICES)-1:0] out_slice,
  output logic busy,
  output logic done
);
  localparam int KW = KERNAL_SIZE * KERNAL_SIZE;
  localparam int PIX = IFM_SIZE * IFM_SIZE;
  localparam int TOTAL = KW * NUMBER_OF_FILTERS * SLICES;
  localparam int CW = $clog2(KW + PIX + CONV_LATENCY + 2);
  localparam int AW = ADDRESS_SIZE_WM;
  localparam int FW = $clog2(NUMBER_OF_FILTERS);
  localparam int SW = $clog2(SLICES);
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_IF, CONV, WAIT, NEXT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [AW-1:0] rd_addr;
  logic [FW-1:0] filter;
  logic [SW-1:0] slice;
  logic rd_en, accept, last_slice, last_filter;
  assign rd_en = (state == LOAD_W) && (cnt < CW'(KW));
  assign busy = state != IDLE;
  assign ifm_ready = state == LOAD_IF;
  assign accept = ifm_valid && ifm_ready;
  assign fifo_enable = accept;
  assign conv_enable = state == CONV;
  assign out_valid = (state == WAIT) && (cnt == CW'(CONV_LATENCY - 1));
  assign out_filter = filter;
  assign out_slice = slice;
  assign last_slice = slice == SW'(SLICES - 1);
  assign last_filter = filter == FW'(NUMBER_OF_FILTERS - 1);
  assign done = (state == NEXT) && last_slice && last_filter;
  assign wm_enable_read = rd_en;
  assign wm_enable_write = (state == IDLE) && host_we;
  assign wm_address = (state == IDLE) ? host_addr : rd_en ? rd_addr : '0;
  assign host_err = host_we && busy;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LOAD_W : IDLE;
      LOAD_W:  state_n = (cnt == CW'(KW)) ? LOAD_IF : LOAD_W;
      LOAD_IF: state_n = (accept && cnt == CW'(PIX - 1)) ? CONV : LOAD_IF;
      CONV:    state_n = WAIT;
      WAIT:    state_n = (cnt == CW'(CONV_LATENCY - 1)) ? NEXT : WAIT;
      NEXT:    state_n = (last_slice && last_filter) ? IDLE : LOAD_W;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rd_addr <= '0;
      filter <= '0;
      slice <= '0;
      wm_fifo_enable <= 1'b0;
    end else begin
      state <= state_n;
      wm_fifo_enable <= rd_en;
      cnt <= (state_n != state || state == IDLE) ? '0 : cnt + ((state == LOAD_IF) ? CW'(accept) : CW'(1));
      if (state == IDLE && start) begin
        rd_addr <= '0;
        filter <= '0;
        slice <= '0;
      end
      if (rd_en) rd_addr <= (rd_addr == AW'(TOTAL - 1)) ? '0 : rd_addr + AW'(1);
      // the final NEXT wraps both indices so the counters read 0 once idle
      if (state == NEXT) begin
        slice <= last_slice ? '0 : slice + SW'(1);
        filter <= last_slice ? (last_filter ? '0 : filter + FW'(1)) : filter;
      end
    end
  end
endmodule

// File: tb/tb_unita_5_ctrl.sv
// tb_unita_5_ctrl: scoreboard bench for the convolution sequencer (2 filters x 3 slices)
module tb_unita_5_ctrl;
  localparam int IFM = 5, K = 5, NF = 2, SL = 3, LAT = 4;
  localparam int KW = K * K, TOT = KW * NF * SL, AW = $clog2(TOT);
  localparam int SLICE_CYC = (KW + 1) + IFM * IFM + 1 + LAT + 1;
  logic clk = 0, reset = 1, start = 0, host_we = 0, ifm_valid = 0;
  logic [AW-1:0] host_addr = '0;
  logic host_err, ifm_ready, wm_enable_read, wm_enable_write, wm_fifo_enable;
  logic fifo_enable, conv_enable, out_valid, busy, done;
  logic [AW-1:0] wm_address;
  logic [0:0] out_filter;
  logic [1:0] out_slice;
  logic [AW+12:0] outs;
  int vecs = 0, errs = 0, cyc = 0, last_ov = -1, exp_addr = 0;
  logic [2:0] sbq[$];
  unita_5_ctrl #(.IFM_SIZE(IFM), .KERNAL_SIZE(K), .NUMBER_OF_FILTERS(NF), .SLICES(SL),
    .CONV_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .host_we(host_we), .host_addr(host_addr),
    .host_err(host_err), .ifm_valid(ifm_valid), .ifm_ready(ifm_ready),
    .wm_enable_read(wm_enable_read), .wm_enable_write(wm_enable_write),
    .wm_address(wm_address), .wm_fifo_enable(wm_fifo_enable), .fifo_enable(fifo_enable),
    .conv_enable(conv_enable), .out_valid(out_valid), .out_filter(out_filter),
    .out_slice(out_slice), .busy(busy), .done(done));
  assign outs = {wm_enable_read, wm_enable_write, wm_address, wm_fifo_enable, fifo_enable,
    conv_enable, out_valid, out_filter, out_slice, busy, done, ifm_ready, host_err};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task test_reset;
    reset = 1; start = 0; host_we = 0; ifm_valid = 0; host_addr = '0;
    repeat (2) @(negedge clk);
    #1 vecs++;
    if (outs !== '0) begin errs++; $display("FAIL reset_outputs got %h exp 0", outs); end
    @(negedge clk) reset = 0;
    #1 vecs++;
    if (outs !== '0) begin errs++; $display("FAIL idle_outputs got %h exp 0", outs); end
  endtask
  task test_host_write;
    @(negedge clk) host_we = 1; host_addr = AW'(10);
    #1 vecs++;
    if (wm_enable_write !== 1'b1 || wm_address !== AW'(10) || host_err !== 1'b0) begin
      errs++; $display("FAIL host_write_idle we=%b addr=%0d err=%b exp 1 10 0", wm_enable_write, wm_address, host_err);
    end
    @(negedge clk) host_we = 0; host_addr = '0;
    #1 vecs++;
    if (wm_enable_write !== 1'b0 || host_err !== 1'b0) begin
      errs++; $display("FAIL host_write_release we=%b err=%b exp 0 0", wm_enable_write, host_err);
    end
  endtask
  task start_run(input bit with_write);
    @(negedge clk) start = 1; host_we = with_write; host_addr = AW'(7);
    #1 vecs++;
    if (wm_enable_write !== with_write || (with_write && wm_address !== AW'(7)) || busy !== 1'b0) begin
      errs++; $display("FAIL start_cycle we=%b addr=%0d busy=%b exp we=%b", wm_enable_write, wm_address, busy, with_write);
    end
    sbq.delete();
    for (int f = 0; f < NF; f++)
      for (int s = 0; s < SL; s++) sbq.push_back(3'(f * 4 + s));
    exp_addr = 0;
    last_ov = -1;
  endtask
  task run_slice(input bit toggle, input bit inject, input bit abort, input bit last);
    int acc, g;
    logic [2:0] e;
    for (int c = 0; c <= KW; c++) begin
      @(negedge clk) start = 0; ifm_valid = 0; host_we = inject && c == 3; host_addr = AW'(10);
      #1 vecs++;
      if (wm_enable_read !== (c < KW) || wm_fifo_enable !== (c > 0) || busy !== 1'b1 || ifm_ready !== 1'b0) begin
        errs++; $display("FAIL load_w c=%0d rd=%b fifo=%b busy=%b exp rd=%b fifo=%b busy=1", c, wm_enable_read, wm_fifo_enable, busy, c < KW, c > 0);
      end
      if (c < KW) begin
        vecs++;
        if (wm_address !== AW'(exp_addr)) begin errs++; $display("FAIL rd_addr got %0d exp %0d", wm_address, exp_addr); end
        exp_addr = (exp_addr + 1) % TOT;
      end
      if (host_we) begin
        vecs++;
        if (wm_enable_write !== 1'b0 || host_err !== 1'b1) begin
          errs++; $display("FAIL host_write_busy we=%b err=%b exp 0 1", wm_enable_write, host_err);
        end
      end
      if (inject && c == 4) begin
        vecs++;
        if (host_err !== 1'b0) begin errs++; $display("FAIL host_err_pulse got %b exp 0", host_err); end
      end
    end
    acc = 0; g = 0;
    while (acc < IFM * IFM && g < 200) begin
      @(negedge clk) host_we = 0; ifm_valid = toggle ? ~g[0] : 1'b1; start = inject && g == 6;
      #1 vecs++;
      if (ifm_ready !== 1'b1 || fifo_enable !== ifm_valid || conv_enable !== 1'b0) begin
        errs++; $display("FAIL ifm_hs g=%0d ready=%b fifo=%b conv=%b exp 1 %b 0", g, ifm_ready, fifo_enable, conv_enable, ifm_valid);
      end
      if (ifm_valid) acc++;
      g++;
    end
    if (acc < IFM * IFM) begin errs++; $display("FAIL ifm_timeout accepted %0d exp %0d", acc, IFM * IFM); end
    @(negedge clk) ifm_valid = 0; start = 0;
    #1 vecs++;
    if (conv_enable !== 1'b1 || ifm_ready !== 1'b0 || fifo_enable !== 1'b0) begin
      errs++; $display("FAIL conv_fire conv=%b ready=%b exp 1 0", conv_enable, ifm_ready);
    end
    for (int w = 0; w < LAT; w++) begin
      @(negedge clk);
      #1 vecs++;
      if (out_valid !== (w == LAT - 1) || conv_enable !== 1'b0) begin
        errs++; $display("FAIL wait w=%0d out_valid=%b conv=%b exp %b 0", w, out_valid, conv_enable, w == LAT - 1);
      end
      if (w == LAT - 1) begin
        vecs++;
        e = (sbq.size() > 0) ? sbq.pop_front() : 3'b111;
        if ({out_filter, out_slice} !== e) begin errs++; $display("FAIL out_index got %0d,%0d exp %0d,%0d", out_filter, out_slice, e[2], e[1:0]); end
        if (last_ov >= 0) begin
          vecs++;
          if (cyc - last_ov != SLICE_CYC) begin errs++; $display("FAIL slice_gap got %0d exp %0d", cyc - last_ov, SLICE_CYC); end
        end
        last_ov = cyc;
      end
      if (abort && w == 1) begin
        reset = 1; host_addr = '0;
        @(negedge clk);
        #1 vecs++;
        if (outs !== '0) begin errs++; $display("FAIL reset_mid_run got %h exp 0", outs); end
        reset = 0;
        sbq.delete();
        return;
      end
    end
    @(negedge clk) start = last;
    #1 vecs++;
    if (done !== last || busy !== 1'b1 || out_valid !== 1'b0) begin
      errs++; $display("FAIL next done=%b busy=%b ov=%b exp %b 1 0", done, busy, out_valid, last);
    end
    if (last) begin
      @(negedge clk) start = 0;
      #1 vecs++;
      if (busy !== 1'b0 || done !== 1'b0 || wm_enable_read !== 1'b0) begin
        errs++; $display("FAIL done_start_ignored busy=%b done=%b rd=%b exp 0 0 0", busy, done, wm_enable_read);
      end
    end
  endtask
  task test_full_run;
    start_run(1);
    for (int f = 0; f < NF; f++)
      for (int s = 0; s < SL; s++)
        run_slice(f == 0 && s == 0, f == 0 && s == 0, 1'b0, f == NF - 1 && s == SL - 1);
    vecs++;
    if (sbq.size() != 0 || exp_addr != 0) begin errs++; $display("FAIL run_complete left %0d results, addr %0d exp 0 0", sbq.size(), exp_addr); end
  endtask
  task test_back_to_back;
    start_run(0);
    run_slice(1'b0, 1'b0, 1'b0, 1'b0);
    run_slice(1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task test_reset_mid_run;
    start_run(0);
    run_slice(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
  endtask
  initial begin
    test_reset;
    test_host_write;
    test_full_run;
    test_back_to_back;
    test_reset_mid_run;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
